// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential packed-BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_MAX = 9;
  localparam int BCD_ADJ = 6;
  localparam int DIGIT_W = 4;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add stage: binary add, then +6 correction above nine.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               c,
  output logic [DIGIT_W-1:0] digit,
  output logic               c_out
);

  logic [DIGIT_W:0] w_s;
  logic             w_gt;

  assign w_s   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, c};
  assign w_gt  = (w_s > (DIGIT_W+1)'(BCD_MAX));
  // Correction wraps mod 16, so non-BCD inputs still give a deterministic digit.
  assign digit = w_gt ? (w_s[DIGIT_W-1:0] + DIGIT_W'(BCD_ADJ)) : w_s[DIGIT_W-1:0];
  assign c_out = w_gt;

endmodule

// File: rtl/bcd_seq_add_ctrl.sv
// Digit-serial packed-BCD adder controller, LSD first, one digit per clock.
// Define BCD_CHECK_EN to flag operand digits above nine on err.
module bcd_seq_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DIGIT_W*NDIG-1:0] a,
  input  logic [DIGIT_W*NDIG-1:0] b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*NDIG-1:0] sum,
  output logic                    cout,
  output logic                    err
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int W     = DIGIT_W * NDIG;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [W-1:0]         r_a;
  logic [W-1:0]         r_b;
  logic [W-1:0]         r_work;
  logic                 r_carry;
  logic                 r_busy;
  logic                 r_done;
  logic [W-1:0]         r_sum;
  logic                 r_cout;

  logic [DIGIT_W-1:0]   w_a_d;
  logic [DIGIT_W-1:0]   w_b_d;
  logic [DIGIT_W-1:0]   w_digit;
  logic                 w_carry;

  assign w_a_d = r_a[r_idx*DIGIT_W +: DIGIT_W];
  assign w_b_d = r_b[r_idx*DIGIT_W +: DIGIT_W];

  bcd_digit_add u_digit_add (
    .a_d   (w_a_d),
    .b_d   (w_b_d),
    .c     (r_carry),
    .digit (w_digit),
    .c_out (w_carry)
  );

`ifdef BCD_CHECK_EN
  logic r_err_acc;
  logic r_err;
  logic w_bad;
  assign w_bad = (w_a_d > DIGIT_W'(BCD_MAX)) || (w_b_d > DIGIT_W'(BCD_MAX));
  assign err   = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef BCD_CHECK_EN
      r_err_acc <= 1'b0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_work  <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
`ifdef BCD_CHECK_EN
            r_err_acc <= 1'b0;
`endif
          end
        end
        RUN: begin
          r_work[r_idx*DIGIT_W +: DIGIT_W] <= w_digit;
          r_carry <= w_carry;
`ifdef BCD_CHECK_EN
          r_err_acc <= r_err_acc | w_bad;
`endif
          if (r_idx == IDX_W'(NDIG-1)) begin
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          // Results become visible together with the done pulse, one edge after the last digit.
          r_sum   <= r_work;
          r_cout  <= r_carry;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
`ifdef BCD_CHECK_EN
          r_err <= r_err_acc;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_bcd_seq_add_ctrl.sv
// Scoreboard bench for bcd_seq_add_ctrl (NDIG=4): expectations queued at start, checked on done.
module tb_bcd_seq_add_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;
`ifdef BCD_CHECK_EN
  localparam logic EXP_BAD_ERR = 1'b1;
`else
  localparam logic EXP_BAD_ERR = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  logic [W-1:0] last_sum;

  bcd_seq_add_ctrl #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, obs, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("err", 32'(err), 32'(e.err));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive a one-cycle start at a negedge while the DUT is idle.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W-1:0] es, input logic ec, input logic ee);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    e.sum = es; e.cout = ec; e.err = ee; e.cyc = cyc + 6;
    q.push_back(e);
    last_sum = es;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; last_sum = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    chk("sum_hold", 32'(sum), 32'(last_sum));

    issue(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain();
    issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    drain();

    // Second request while busy must be dropped.
    issue(16'h0555, 16'h0445, 1'b0, 16'h1000, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_inflight", 32'(busy), 32'd1);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (8) @(negedge clk);

    // Abort two cycles into RUN.
    issue(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 32'(q.size()), 32'd0);

    issue(16'h0009, 16'h0009, 1'b0, 16'h0018, 1'b0, 1'b0);
    drain();

    issue(16'h000A, 16'h0001, 1'b0, 16'h0011, 1'b0, EXP_BAD_ERR);
    drain();
    issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    drain();

    // start held high for 20 cycles: accepts at edges 1, 7, 13, 19 after assertion.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    for (int j = 0; 1 + 6 * j <= 20; j++) begin
      exp_t e;
      e.sum = 16'h0002; e.cout = 1'b0; e.err = 1'b0; e.cyc = cyc + 6 + 6 * j;
      q.push_back(e);
    end
    repeat (20) @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_seq_add_ctrl.md
Name: bcd_seq_add_ctrl

Overview:
- Sequencing controller for multi-digit packed-BCD addition.
- Reuses one single-digit BCD add stage and processes one digit per clock, least-significant digit first.
- Digit carry is registered between steps.
- Sits between a requester (start/done handshake) and downstream logic that consumes the packed BCD result.

Parameters:
- NDIG, 4, number of BCD digits per operand (≥1); operand/result width is 4*NDIG.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  4*NDIG  packed BCD operand A; digit 0 in bits [3:0].
- b  input  4*NDIG  packed BCD operand B.
- cin  input  1  carry into digit 0.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  4*NDIG  packed BCD result; held until the next done.
- cout  output  1  carry out of the top digit; held with sum.
- err  output  1  invalid-digit flag (see Optional Feature); held with sum.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, digit index=0, carry reg=0, operand regs=0.
- States:
  - IDLE: on start=1, latch a, b, and cin into the carry reg; clear index and the working-sum reg; go to RUN.
  - RUN: each cycle add digit[idx] of A and B plus the carry reg.
    - Write the result digit into working-sum[idx] and update the carry reg.
    - If idx==NDIG-1, go to DONE; otherwise idx++.
  - DONE: copy working-sum→sum, carry→cout, err accumulator→err; assert done=1 for this cycle only; go to IDLE.
- Latency: start sampled at edge E0 → done high during the cycle after edge E0+NDIG+1 edges; fixed NDIG+2 cycles start-to-start minimum.
- Digit add rule (5-bit): s = a_d + b_d + c.
  - If s > 9: digit = (s+6)[3:0], c' = 1.
  - Else: digit = s[3:0], c' = 0.
  - Applies to non-BCD inputs too; the result is deterministic but not meaningful decimal.
- start while busy: ignored (no queueing); the in-flight operation is unaffected.
- Operand changes after acceptance: no effect; operands are registered.
- start held high continuously: a new operation is accepted on each return to IDLE (one IDLE cycle between operations).
- sum/cout/err change only in DONE or on reset.
- Reset mid-operation: aborts immediately; all outputs return to reset values; no done is issued.
- NDIG=1: RUN lasts one cycle.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - During RUN, accumulate (OR) a flag if any a_d > 9 or b_d > 9.
  - err presents the accumulated flag in DONE and holds it.
  - The computed sum is still produced by the normal rule.
- Not defined: no check logic; err is tied to 0. The port stays present so the interface is stable.

Decomposition:
- Shared package bcd_pkg: state enum (IDLE, RUN, DONE); constants BCD_MAX=9, BCD_ADJ=6, DIGIT_W=4.
- One combinational sub-module is natural: bcd_digit_add (inputs a_d[3:0], b_d[3:0], c; outputs digit[3:0], c').
- The controller holds the FSM, index counter, operand/carry/working registers, and err accumulator.

Test Plan (NDIG=4):
- a=0x1234, b=0x5678, cin=0, start pulse → done exactly 5 cycles after the start edge; sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1; a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0.
- Accept a=0x0555, b=0x0445, cin=0; pulse start with a=0x1111, b=0x1111 while busy → single done with sum=0x1000, cout=0; the second request is ignored.
- Deassert rst_n two cycles into RUN → busy, done, sum, cout, err are 0 immediately.
  - After release, a new start a=0x0009, b=0x0009 → sum=0x0018.
- BCD_CHECK_EN defined: a=0x000A, b=0x0001, cin=0 → err=1, sum=0x0011, cout=0.
  - Macro undefined, same stimulus → err=0, sum=0x0011.
- start held high for 20 cycles with a=0x0001, b=0x0001 → done pulses every 6 cycles, each with sum=0x0002.
